// File: rtl/huff_pkg.sv
// -----------------------------------------------------------------------------
// huff_pkg
// Shared definitions for the streaming Huffman decoder:
//   - the canonical code table (first code, count and symbol offset for each
//     codeword length, plus the symbol list in canonical order)
//   - the decoder state enum
//   - huff_lookup(): canonical match of a MAX_CODE-bit MSB-aligned window,
//     returning {hit, len, sym}
// No ports (package).
// -----------------------------------------------------------------------------
package huff_pkg;

  localparam int CODE_MAX = 9;  // longest codeword in the table
  localparam int SYM_BITS = 4;  // signed symbol width
  localparam int LEN_BITS = 4;  // holds a codeword length 0..CODE_MAX

  typedef enum logic [1:0] {RUN, DRAIN, ERR} state_t;

  typedef struct packed {
    logic                       hit;
    logic [LEN_BITS-1:0]        len;
    logic signed [SYM_BITS-1:0] sym;
  } match_t;

  // Indexed by codeword length; entries 0 and 1 are unused (no such codes).
  // Length 9 holds three codes (444..446); 447 = 110111111 is left invalid.
  localparam int FIRST_CODE [10] = '{0, 0, 0, 4, 10, 24, 52, 108, 220, 444};
  localparam int CODE_COUNT [10] = '{0, 0, 2, 1,  2,  2,  2,   2,   2,   3};
  localparam int SYM_OFFSET [10] = '{0, 0, 0, 2,  3,  5,  7,   9,  11,  13};

  // Symbols in canonical order: 0, 1, -1, 2, -2, ... 7, -7, -8.
  localparam logic signed [SYM_BITS-1:0] SYMBOLS [16] = '{
    4'sd0, 4'sd1, -4'sd1, 4'sd2, -4'sd2, 4'sd3, -4'sd3, 4'sd4,
    -4'sd4, 4'sd5, -4'sd5, 4'sd6, -4'sd6, 4'sd7, -4'sd7, 4'b1000
  };

  // Canonical decode: a length-L code matches when its top-L-bit value lies in
  // [FIRST_CODE[L], FIRST_CODE[L]+CODE_COUNT[L]) and L bits are available.
  // The code is prefix-free, so the shortest match is the only match.
  function automatic match_t huff_lookup(input logic [CODE_MAX-1:0] window,
                                         input int                  avail);
    match_t              r;
    int                  code;
    logic [3:0]          li;
    logic [3:0]          idx;
    r = '0;
    for (int l = 1; l <= CODE_MAX; l++) begin
      li   = 4'(l);
      code = int'(window >> (CODE_MAX - l));
      if (!r.hit && l <= avail && code >= FIRST_CODE[li] &&
          code < FIRST_CODE[li] + CODE_COUNT[li]) begin
        idx   = 4'(SYM_OFFSET[li] + code - FIRST_CODE[li]);
        r.hit = 1'b1;
        r.len = LEN_BITS'(l);
        r.sym = SYMBOLS[idx];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/huff_stream_decoder_if.sv
// -----------------------------------------------------------------------------
// huff_stream_decoder_if
// Bundles the decoder's stream-side signals.
//   Upstream  : sValid, sReady, in_bits[IN_W], in_len, flush
//   Downstream: decodedData (signed), tvalid, tready
//   Status    : done, residue[CNT_W], err
// Modports: slave = the decoder, master = whatever drives/consumes it.
// -----------------------------------------------------------------------------
interface huff_stream_decoder_if #(
  parameter int IN_W     = 8,
  parameter int MAX_CODE = 9,
  parameter int SYM_W    = 4
);
  localparam int BUF_W = MAX_CODE + IN_W;
  localparam int CNT_W = $clog2(BUF_W + 1);
  localparam int LEN_W = $clog2(IN_W + 1);

  logic                    sValid;
  logic                    sReady;
  logic [IN_W-1:0]         in_bits;
  logic [LEN_W-1:0]        in_len;
  logic                    flush;
  logic signed [SYM_W-1:0] decodedData;
  logic                    tvalid;
  logic                    tready;
  logic                    done;
  logic [CNT_W-1:0]        residue;
  logic                    err;

  modport master (
    output sValid, in_bits, in_len, flush, tready,
    input  sReady, decodedData, tvalid, done, residue, err
  );

  modport slave (
    input  sValid, in_bits, in_len, flush, tready,
    output sReady, decodedData, tvalid, done, residue, err
  );
endinterface

// File: rtl/huff_match.sv
// -----------------------------------------------------------------------------
// huff_match
// Combinational canonical-Huffman matcher over the top CODE_MAX bits of the
// bit buffer.
//   window    in  CODE_MAX  buffer MSBs, first stream bit at the top
//   bit_count in  CNT_W     valid bits in the buffer (limits usable length)
//   hit       out 1         a complete codeword is present
//   len       out LEN_BITS  its length
//   sym       out SYM_BITS  decoded signed symbol
// -----------------------------------------------------------------------------
module huff_match
  import huff_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic [CODE_MAX-1:0]        window,
  input  logic [CNT_W-1:0]           bit_count,
  output logic                       hit,
  output logic [LEN_BITS-1:0]        len,
  output logic signed [SYM_BITS-1:0] sym
);
  match_t m;

  always_comb begin
    m = huff_lookup(window, int'(bit_count));
  end

  assign hit = m.hit;
  assign len = m.len;
  assign sym = m.sym;
endmodule

// File: rtl/huff_stream_decoder.sv
// -----------------------------------------------------------------------------
// huff_stream_decoder
// Streaming canonical-Huffman decoder. Variable-length chunks are appended to
// an MSB-aligned bit buffer; one codeword per cycle is decoded from its top.
//   clk   in  rising-edge clock
//   reset in  asynchronous, active-low reset
//   bus   slave modport of huff_stream_decoder_if (chunk input with
//         valid/ready, symbol output with valid/ready, flush/done/residue,
//         sticky err)
// -----------------------------------------------------------------------------
module huff_stream_decoder
  import huff_pkg::*;
#(
  parameter int IN_W     = 8,
  parameter int MAX_CODE = 9,
  parameter int SYM_W    = 4
) (
  input logic                   clk,
  input logic                   reset,
  huff_stream_decoder_if.slave  bus
);
  localparam int BUF_W = MAX_CODE + IN_W;
  localparam int CNT_W = $clog2(BUF_W + 1);
  localparam int LEN_W = $clog2(IN_W + 1);
  localparam int THR   = BUF_W - IN_W;  // room for one more full chunk

  state_t                  state;
  logic [BUF_W-1:0]        buf_q;
  logic [CNT_W-1:0]        bit_count;
  logic                    sready_q;
  logic                    tvalid_q;
  logic signed [SYM_W-1:0] data_q;
  logic                    done_q;
  logic [CNT_W-1:0]        residue_q;
  logic                    err_q;

  logic [MAX_CODE-1:0]        window;
  logic                       hit;
  logic [LEN_BITS-1:0]        len;
  logic signed [SYM_BITS-1:0] sym;

  logic             fire;
  logic             chunk_ok;
  logic             err_cond;
  logic [IN_W-1:0]  mask;
  logic [BUF_W-1:0] chunk_top;
  logic [BUF_W-1:0] buf_shift;
  logic [CNT_W-1:0] count_shift;
  logic [BUF_W-1:0] buf_next;
  logic [CNT_W-1:0] count_next;

  assign window = buf_q[BUF_W-1 -: MAX_CODE];

  huff_match #(.CNT_W(CNT_W)) u_match (
    .window    (window),
    .bit_count (bit_count),
    .hit       (hit),
    .len       (len),
    .sym       (sym)
  );

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    fire        = 1'b0;
    chunk_ok    = 1'b0;
    err_cond    = 1'b0;
    mask        = '0;
    chunk_top   = '0;
    buf_shift   = buf_q;
    count_shift = bit_count;
    buf_next    = buf_q;
    count_next  = bit_count;

    // The output slot is free when empty or being consumed this edge.
    fire     = hit && (!tvalid_q || bus.tready) && (state != ERR);
    // Zero-length (or oversize) chunks complete the handshake but add nothing.
    chunk_ok = bus.sValid && sready_q && (bus.in_len != '0) &&
               (bus.in_len <= LEN_W'(IN_W));
    err_cond = (bit_count >= CNT_W'(MAX_CODE)) && !hit;

    if (fire) begin
      buf_shift   = buf_q << len;
      count_shift = bit_count - CNT_W'(len);
    end

    // Move the chunk's first bit (in_bits[in_len-1]) to the buffer MSB, then
    // slide it down below the bits still held after this cycle's decode.
    mask      = ~({IN_W{1'b1}} << bus.in_len);
    chunk_top = {bus.in_bits & mask, {(BUF_W-IN_W){1'b0}}} << (LEN_W'(IN_W) - bus.in_len);

    buf_next   = buf_shift;
    count_next = count_shift;
    if (chunk_ok) begin
      buf_next   = buf_shift | (chunk_top >> count_shift);
      count_next = count_shift + CNT_W'(bus.in_len);
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  // NOTE: the bit buffer is reset with bit_count because appends OR into the
  // bits below bit_count, which must therefore always be zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      buf_q     <= '0;
      bit_count <= '0;
      sready_q  <= 1'b0;
      tvalid_q  <= 1'b0;
      data_q    <= '0;
      done_q    <= 1'b0;
      residue_q <= '0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (fire) begin
        tvalid_q <= 1'b1;
        data_q   <= SYM_W'(sym);
      end else if (bus.tready) begin
        tvalid_q <= 1'b0;
      end

      case (state)
        RUN: begin
          buf_q     <= buf_next;
          bit_count <= count_next;
          if (bus.flush) begin
            state    <= DRAIN;
            sready_q <= 1'b0;
          end else if (err_cond) begin
            state    <= ERR;
            err_q    <= 1'b1;
            sready_q <= 1'b0;
          end else begin
            sready_q <= (count_next <= CNT_W'(THR));
          end
        end

        DRAIN: begin
          // Upstream is stalled here, so only decodes move the buffer.
          if (!hit && !tvalid_q) begin
            state     <= RUN;
            done_q    <= 1'b1;
            residue_q <= bit_count;
            buf_q     <= '0;
            bit_count <= '0;
            sready_q  <= 1'b1;
          end else begin
            buf_q     <= buf_next;
            bit_count <= count_next;
            sready_q  <= 1'b0;
          end
        end

        ERR: begin
          if (bus.flush) begin
            state     <= RUN;
            err_q     <= 1'b0;
            buf_q     <= '0;
            bit_count <= '0;
            sready_q  <= 1'b1;
          end else begin
            sready_q <= 1'b0;
          end
        end

        default: state <= RUN;
      endcase
    end
  end

  assign bus.sReady      = sready_q;
  assign bus.tvalid      = tvalid_q;
  assign bus.decodedData = data_q;
  assign bus.done        = done_q;
  assign bus.residue     = residue_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_huff_stream_decoder.sv
// -----------------------------------------------------------------------------
// tb_huff_stream_decoder
// Directed bench for huff_stream_decoder. Inputs change 1 time unit after the
// rising edge; outputs and handshakes are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_huff_stream_decoder;
  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  logic signed [3:0] sym_q[$];
  int                cyc_q[$];

  huff_stream_decoder_if #(.IN_W(8), .MAX_CODE(9), .SYM_W(4)) bus ();

  huff_stream_decoder #(.IN_W(8), .MAX_CODE(9), .SYM_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every output handshake with the cycle it happened in.
  always @(negedge clk) begin
    if (reset && bus.tvalid && bus.tready) begin
      sym_q.push_back(bus.decodedData);
      cyc_q.push_back(cyc);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_chunk(input logic [7:0] bits, input logic [3:0] len, input string tag);
    int waited = 0;
    bus.sValid  = 1'b1;
    bus.in_bits = bits;
    bus.in_len  = len;
    @(negedge clk);
    while (!bus.sReady && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.sReady) begin
      checks++;
      errors++;
      $display("FAIL %s_accept: sReady got 0 expected 1 within 200 cycles", tag);
    end
    @(posedge clk);
    #1;
    bus.sValid  = 1'b0;
    bus.in_bits = '0;
    bus.in_len  = '0;
  endtask

  task automatic wait_syms(input int n, input int budget);
    int k = 0;
    while (sym_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.sReady !== 1'b0) begin errors++; $display("FAIL rst_sready: got %b expected 0", bus.sReady); end
    checks++; if (bus.tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b expected 0", bus.tvalid); end
    checks++; if (bus.decodedData !== 4'd0) begin errors++; $display("FAIL rst_data: got %0d expected 0", bus.decodedData); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", bus.done); end
    checks++; if (bus.residue !== 5'd0) begin errors++; $display("FAIL rst_residue: got %0d expected 0", bus.residue); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", bus.err); end
    reset = 1'b1;
    #1;
    checks++; if (bus.sReady !== 1'b0) begin errors++; $display("FAIL rst_release_sready: got %b expected 0", bus.sReady); end
    @(posedge clk);
    #1;
    checks++; if (bus.sReady !== 1'b1) begin errors++; $display("FAIL rst_first_clk_sready: got %b expected 1", bus.sReady); end
    // A zero-length chunk is accepted and contributes no bits.
    send_chunk(8'hFF, 4'd0, "len0");
    repeat (2) @(posedge clk);
    #1;
    checks++; if (dut.bit_count !== 5'd0) begin errors++; $display("FAIL len0_count: got %0d expected 0", dut.bit_count); end
    checks++; if (bus.tvalid !== 1'b0) begin errors++; $display("FAIL len0_tvalid: got %b expected 0", bus.tvalid); end
  endtask

  task automatic test_basic();
    logic signed [3:0] exp_s [4] = '{4'sd0, 4'sd1, -4'sd1, 4'sd2};
    logic signed [3:0] got;
    sym_q.delete();
    cyc_q.delete();
    send_chunk(8'b00011001, 4'd8, "basic0");
    send_chunk(8'b00000010, 4'd3, "basic1");
    wait_syms(4, 40);
    checks++; if (sym_q.size() != 4) begin errors++; $display("FAIL basic_count: got %0d symbols expected 4", sym_q.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < sym_q.size()) ? sym_q[i] : 4'bxxxx;
      checks++;
      if (got !== exp_s[i]) begin
        errors++;
        $display("FAIL basic_sym%0d: got %0d expected %0d", i, got, exp_s[i]);
      end
    end
    checks++;
    if (cyc_q.size() != 4 || cyc_q[3] - cyc_q[0] != 3) begin
      errors++;
      $display("FAIL basic_back_to_back: got span %0d expected 3", (cyc_q.size() == 4) ? cyc_q[3] - cyc_q[0] : -1);
    end
    checks++; if (dut.bit_count !== 5'd0) begin errors++; $display("FAIL basic_bitcount: got %0d expected 0", dut.bit_count); end
  endtask

  task automatic test_long_code();
    sym_q.delete();
    cyc_q.delete();
    send_chunk(8'b00001101, 4'd4, "long0");
    checks++; if (bus.tvalid !== 1'b0) begin errors++; $display("FAIL long_partial_tvalid: got %b expected 0", bus.tvalid); end
    send_chunk(8'b00011110, 4'd5, "long1");
    checks++; if (bus.tvalid !== 1'b0) begin errors++; $display("FAIL long_accept_edge_tvalid: got %b expected 0", bus.tvalid); end
    @(posedge clk);
    #1;
    checks++; if (bus.tvalid !== 1'b1) begin errors++; $display("FAIL long_latency_tvalid: got %b expected 1", bus.tvalid); end
    checks++; if (bus.decodedData !== 4'b1000) begin errors++; $display("FAIL long_sym: got %0d expected -8", bus.decodedData); end
    wait_syms(1, 10);
    checks++; if (sym_q.size() != 1) begin errors++; $display("FAIL long_count: got %0d symbols expected 1", sym_q.size()); end
  endtask

  task automatic test_stall();
    int nonzero = 0;
    sym_q.delete();
    cyc_q.delete();
    bus.tready = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send_chunk(8'h00, 4'd8, "stall");
      end
      begin
        repeat (12) @(posedge clk);
        #1;
        checks++; if (bus.tvalid !== 1'b1) begin errors++; $display("FAIL stall_tvalid: got %b expected 1", bus.tvalid); end
        checks++; if (bus.decodedData !== 4'd0) begin errors++; $display("FAIL stall_data: got %0d expected 0", bus.decodedData); end
        checks++; if (bus.sReady !== 1'b0) begin errors++; $display("FAIL stall_sready: got %b expected 0", bus.sReady); end
        checks++; if (dut.bit_count !== 5'd14) begin errors++; $display("FAIL stall_bitcount: got %0d expected 14", dut.bit_count); end
        checks++; if (sym_q.size() != 0) begin errors++; $display("FAIL stall_no_handshake: got %0d expected 0", sym_q.size()); end
        bus.tready = 1'b1;
      end
    join
    wait_syms(32, 400);
    checks++; if (sym_q.size() != 32) begin errors++; $display("FAIL stall_drain_count: got %0d symbols expected 32", sym_q.size()); end
    foreach (sym_q[i]) if (sym_q[i] !== 4'sd0) nonzero++;
    checks++; if (nonzero != 0) begin errors++; $display("FAIL stall_drain_values: got %0d nonzero symbols expected 0", nonzero); end
    checks++; if (dut.bit_count !== 5'd0) begin errors++; $display("FAIL stall_bitcount_end: got %0d expected 0", dut.bit_count); end
  endtask

  task automatic test_invalid();
    sym_q.delete();
    cyc_q.delete();
    send_chunk(8'b11011111, 4'd8, "inv0");
    send_chunk(8'b00000001, 4'd1, "inv1");
    @(posedge clk);
    #1;
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL inv_err: got %b expected 1", bus.err); end
    checks++; if (bus.sReady !== 1'b0) begin errors++; $display("FAIL inv_sready: got %b expected 0", bus.sReady); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL inv_err_sticky: got %b expected 1", bus.err); end
    checks++; if (sym_q.size() != 0 || bus.tvalid !== 1'b0) begin errors++; $display("FAIL inv_no_tvalid: got %0d symbols tvalid %b expected 0 and 0", sym_q.size(), bus.tvalid); end
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL inv_flush_err: got %b expected 0", bus.err); end
    checks++; if (bus.sReady !== 1'b1) begin errors++; $display("FAIL inv_flush_sready: got %b expected 1", bus.sReady); end
    checks++; if (dut.bit_count !== 5'd0) begin errors++; $display("FAIL inv_flush_bitcount: got %0d expected 0", dut.bit_count); end
  endtask

  task automatic test_flush_residue();
    int          done_cnt = 0;
    logic [4:0]  res      = '0;
    sym_q.delete();
    cyc_q.delete();
    send_chunk(8'b00000110, 4'd3, "res0");
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        done_cnt++;
        res = bus.residue;
      end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL flush_done_pulses: got %0d expected 1", done_cnt); end
    checks++; if (res !== 5'd3) begin errors++; $display("FAIL flush_residue: got %0d expected 3", res); end
    checks++; if (sym_q.size() != 0) begin errors++; $display("FAIL flush_no_tvalid: got %0d symbols expected 0", sym_q.size()); end
    checks++; if (bus.sReady !== 1'b1) begin errors++; $display("FAIL flush_sready: got %b expected 1", bus.sReady); end
  endtask

  task automatic test_reset_mid();
    logic signed [3:0] exp_s [3] = '{-4'sd3, -4'sd1, -4'sd4};
    logic signed [3:0] got;
    bus.tready = 1'b0;
    send_chunk(8'b01010101, 4'd8, "mid0");
    @(posedge clk);
    #1;
    checks++; if (bus.tvalid !== 1'b1) begin errors++; $display("FAIL mid_pre_tvalid: got %b expected 1", bus.tvalid); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (bus.tvalid !== 1'b0) begin errors++; $display("FAIL mid_rst_tvalid: got %b expected 0", bus.tvalid); end
    checks++; if (bus.decodedData !== 4'd0) begin errors++; $display("FAIL mid_rst_data: got %0d expected 0", bus.decodedData); end
    checks++; if (bus.sReady !== 1'b0) begin errors++; $display("FAIL mid_rst_sready: got %b expected 0", bus.sReady); end
    checks++; if (bus.residue !== 5'd0) begin errors++; $display("FAIL mid_rst_residue: got %0d expected 0", bus.residue); end
    checks++; if (bus.done !== 1'b0 || bus.err !== 1'b0) begin errors++; $display("FAIL mid_rst_status: got done %b err %b expected 0 0", bus.done, bus.err); end
    checks++; if (dut.bit_count !== 5'd0) begin errors++; $display("FAIL mid_rst_bitcount: got %0d expected 0", dut.bit_count); end
    sym_q.delete();
    cyc_q.delete();
    @(posedge clk);
    #1;
    reset      = 1'b1;
    bus.tready = 1'b1;
    @(posedge clk);
    #1;
    send_chunk(8'b11001100, 4'd8, "mid1");
    send_chunk(8'b00110101, 4'd6, "mid2");
    wait_syms(3, 40);
    checks++; if (sym_q.size() != 3) begin errors++; $display("FAIL mid_fresh_count: got %0d symbols expected 3", sym_q.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < sym_q.size()) ? sym_q[i] : 4'bxxxx;
      checks++;
      if (got !== exp_s[i]) begin
        errors++;
        $display("FAIL mid_fresh_sym%0d: got %0d expected %0d", i, got, exp_s[i]);
      end
    end
  endtask

  initial begin
    bus.sValid  = 1'b0;
    bus.in_bits = '0;
    bus.in_len  = '0;
    bus.flush   = 1'b0;
    bus.tready  = 1'b1;
    test_reset();
    test_basic();
    test_long_code();
    test_stall();
    test_invalid();
    test_flush_residue();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/huff_stream_decoder.md
# huff_stream_decoder

Parametrised streaming Huffman decoder, successor to the fixed 4-bit-chunk shift-register decoder. It accepts variable-length bit chunks of up to IN_W bits and decodes one canonical-Huffman codeword per cycle into a signed symbol. Upstream and downstream use valid/ready handshakes, so the block can sit between a packet unpacker and a sample FIFO. It also adds end-of-stream flush, residue reporting and invalid-code detection.

## Interface
- IN_W, 8: maximum chunk width in bits.
- MAX_CODE, 9: longest codeword length.
- SYM_W, 4: signed output symbol width.
- BUF_W, MAX_CODE+IN_W: bit-buffer depth (derived, not overridden).
- CNT_W, $clog2(BUF_W+1): bit-count width (derived).
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- sValid  in  1  chunk valid.
- sReady  out  1  chunk accepted when sValid&sReady.
- in_bits  in  IN_W  chunk payload. Bits [in_len-1:0] are used; in_bits[in_len-1] is the first bit in stream order.
- in_len  in  $clog2(IN_W+1)  chunk length, 1..IN_W. A value of 0 is accepted and ignored.
- flush  in  1  end-of-stream pulse; also clears the error state.
- decodedData  out  SYM_W  signed decoded symbol.
- tvalid  out  1  symbol valid.
- tready  in  1  downstream ready.
- done  out  1  one-cycle pulse when a flush completes.
- residue  out  CNT_W  leftover undecodable bits at flush; valid with done.
- err  out  1  sticky invalid-codeword flag.

## Operation
- **Bit buffer.** The buffer is BUF_W bits, MSB-aligned, with a bit_count register. An accepted chunk is appended below the existing bits.
- **Decode.** The symbol is taken from the buffer MSBs using the package code table. A codeword of length L matches only if L ≤ bit_count.
- **Code table (canonical, package constant):**
  - 0 = 00, 1 = 01, -1 = 100
  - 2 = 1010, -2 = 1011
  - 3 = 11000, -3 = 11001
  - 4 = 110100, -4 = 110101
  - 5 = 1101100, -5 = 1101101
  - 6 = 11011100, -6 = 11011101
  - 7 = 110111100, -7 = 110111101, -8 = 110111110
  - 110111111 is invalid.
- **sReady.** sReady = (state==RUN) && (bit_count ≤ BUF_W−IN_W). It depends on registers only; there is no path from tready.
- **Decode fire.** A decode fires when a match exists and (!tvalid || tready). Firing shifts out L bits, loads decodedData and sets tvalid.
- **Accept and fire together.** Accept and fire may occur in the same cycle: new_count = bit_count − L + in_len.
- **States:**
  - RUN → DRAIN on flush.
  - RUN → ERR when bit_count ≥ MAX_CODE and there is no match.
  - DRAIN → RUN when no match remains and the output is empty. This transition pulses done, sets residue = bit_count, and clears the buffer and bit_count.
  - ERR: sets err, holds sReady low and stops decoding; a pending output may still drain. ERR → RUN on flush, which clears the buffer and err; done is not pulsed.
- flush while already in DRAIN is ignored.

## Timing
- **Reset values:** sReady=0, tvalid=0, decodedData=0, done=0, residue=0, err=0, bit_count=0, state=RUN. sReady rises on the first clock after reset release.
- **Latency:** when a chunk completing a codeword is accepted at edge N, tvalid is high after edge N+1.
- **Throughput:** 1 symbol/cycle while the buffer holds a complete codeword and tready=1.
- **Output stall:** when tvalid && !tready, decodedData and tvalid hold and no decode fires.
- **Output clear:** tvalid drops after a handshake edge when no new decode fires.
- **No deadlock:** bit_count ≥ MAX_CODE always leads to a match or to ERR.
- **Reset mid-stream:** asynchronous clear of all state. No partial output appears afterwards.

## Structure
- Package huff_pkg holds:
  - the code-table constants: per-length first code, count, symbol offset, and the symbol list;
  - the state enum {RUN, DRAIN, ERR};
  - a function returning {hit, len, sym} from a MAX_CODE-bit window plus bit_count.
- One sub-module, huff_match: the combinational canonical matcher. The top level holds the buffer, the FSM and the output register.

## Test plan
- Chunk 8'b00011001 len 8, then 3'b010 len 3, with tready=1 → symbols 0, 1, −1, 2 on consecutive tvalid beats; bit_count ends at 0.
- Chunk 4'b1101 len 4, then 5'b11110 len 5 → a single symbol −8; tvalid rises 1 cycle after the second accept.
- Eight 8-bit chunks of all-zero bits with tready=0 → exactly one tvalid held with value 0. sReady drops once bit_count > 9. After tready rises, 32 zero symbols emerge with no loss.
- Stream 9'b110111111 → err=1, sReady=0, no tvalid. Then a flush pulse → err=0 and sReady=1 next cycle.
- Chunk 3'b110 len 3, then flush → no tvalid; done pulses once with residue=3.
- Assert reset low mid-stream with tvalid high → all outputs take their reset values immediately. A fresh stream afterwards decodes correctly.
